// File: rtl/pipe_pkg.sv
// Shared pipeline types: execute-to-memory control word, load/store size
// encodings and the EX/MEM skid-buffer occupancy states.
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic [2:0] funct3;
    } ex_mem_ctrl_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/mem_align_chk.sv
// Load/store alignment check: flags an access whose low address bits do not
// suit the access size encoded in funct3. Purely combinational.
module mem_align_chk
    import pipe_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] funct3,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       misaligned
);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the output unassigned and a latch is inferred.
        misaligned = 1'b0;
        if (mem_read || mem_write) begin
            case (funct3)
                F3_W:        misaligned = (addr != 2'b00);
                F3_H, F3_HU: misaligned = addr[0];
                default:     misaligned = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer: captures ALU result,
// store data and control, resolves branches and flags misaligned accesses.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic [DATA_WIDTH-1:0]     ex_rs2_data,
    input  logic [DATA_WIDTH-1:0]     ex_pc,
    input  logic [DATA_WIDTH-1:0]     ex_imm,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  ex_mem_ctrl_t              ex_ctrl,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_alu_result,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output ex_mem_ctrl_t              mem_ctrl,
    output logic                      mem_misaligned,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [REG_ADDR_WIDTH-1:0] rd;
        ex_mem_ctrl_t              ctrl;
        logic                      misaligned;
    } entry_t;

    occ_t   state, state_nxt;
    entry_t head, skid, in_entry;
    logic   accept, retire, taken, in_misaligned;

    mem_align_chk u_align (
        .addr       (ALUResult[1:0]),
        .funct3     (ex_ctrl.funct3),
        .mem_read   (ex_ctrl.mem_read),
        .mem_write  (ex_ctrl.mem_write),
        .misaligned (in_misaligned)
    );

    assign accept   = ex_valid & ex_ready;
    assign retire   = mem_valid & mem_ready;
    assign taken    = ex_ctrl.branch & ALUResult[0];
    assign in_entry = '{alu_result: ALUResult, wdata: ex_rs2_data, rd: ex_rd,
                        ctrl: ex_ctrl, misaligned: in_misaligned};

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !retire)      state_nxt = TWO;
                    else if (!accept && retire) state_nxt = EMPTY;
                end
                TWO:     if (retire) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ex_ready and mem_valid are decoded from the next state and registered so
    // neither output depends combinationally on mem_ready or ex_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= EMPTY;
            ex_ready       <= 1'b0;
            mem_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            // NOTE: the entry registers are reset only because the data outputs must read zero out of reset.
            head           <= '0;
            skid           <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop here samples pre-edge values regardless of statement order.
            state          <= state_nxt;
            ex_ready       <= (state_nxt != TWO);
            mem_valid      <= (state_nxt != EMPTY);
            redirect_valid <= accept & taken & ~flush;
            if (accept && taken && !flush) redirect_pc <= ex_pc + ex_imm;

            if (!flush) begin
                case (state)
                    EMPTY: if (accept) head <= in_entry;
                    ONE: begin
                        if (accept && retire) head <= in_entry;
                        else if (accept)      skid <= in_entry;
                    end
                    TWO:     if (retire) head <= skid;
                    default: ;
                endcase
            end
        end
    end

    assign mem_alu_result = head.alu_result;
    assign mem_wdata      = head.wdata;
    assign mem_rd         = head.rd;
    assign mem_ctrl       = head.ctrl;
    assign mem_misaligned = head.misaligned;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver pushes expected entries from a
// queue-based model, the monitor pops and compares on every MEM handshake.
module tb_ex_mem_stage;
    import pipe_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1, flush = 1'b0, ex_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0]  alu_in = '0, rs2_in = '0, pc_in = '0, imm_in = '0;
    logic [4:0]   rd_in = '0;
    ex_mem_ctrl_t ctrl_in = '0;
    logic         ex_ready, mem_valid, mem_misaligned, redirect_valid;
    logic [31:0]  mem_alu_result, mem_wdata, redirect_pc;
    logic [4:0]   mem_rd;
    ex_mem_ctrl_t mem_ctrl;

    ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ALUResult(alu_in), .ex_rs2_data(rs2_in), .ex_pc(pc_in), .ex_imm(imm_in),
        .ex_rd(rd_in), .ex_ctrl(ctrl_in),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_alu_result(mem_alu_result), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_ctrl(mem_ctrl), .mem_misaligned(mem_misaligned),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [31:0]  alu, rs2, pc, imm;
        logic [4:0]   rd;
        ex_mem_ctrl_t c;
    } stim_t;

    typedef struct {
        logic [31:0]  alu, wdata;
        logic [4:0]   rd;
        ex_mem_ctrl_t ctrl;
        logic         mis;
    } exp_t;

    exp_t        exp_q[$];
    int          cnt = 0;
    logic        exp_ready = 1'b0, exp_redir = 1'b0;
    logic [31:0] exp_rpc = '0;
    bit          chk_en = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    stim_t       idle = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Access size in bytes is 1 << funct3[1:0]; an access is misaligned when
    // the address is not a multiple of its size.
    function automatic logic model_mis(input logic [31:0] addr, input ex_mem_ctrl_t c);
        int unsigned size;
        size = 1 << c.funct3[1:0];
        if (!(c.mem_read || c.mem_write)) return 1'b0;
        return (addr % size) != 0;
    endfunction

    function automatic stim_t mk(input logic [31:0] alu, input logic rdm, input logic wr,
                                 input logic br, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] imm);
        stim_t s;
        s.v   = 1'b1;
        s.alu = alu;
        s.rs2 = $urandom();
        s.pc  = pc;
        s.imm = imm;
        s.rd  = 5'($urandom_range(1, 31));
        s.c   = '{reg_write: !wr && !br, mem_read: rdm, mem_write: wr,
                  mem_to_reg: rdm, branch: br, funct3: f3};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        logic [2:0] f3s [5];
        int         kind;
        stim_t      s;
        f3s  = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        kind = $urandom_range(0, 3);
        s = mk($urandom(), kind == 1, kind == 2, kind == 3,
               f3s[$urandom_range(0, 4)], $urandom(), $urandom());
        s.v = ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    // One clock: drive, predict, then update the model just after the edge.
    task automatic step(input stim_t s, input logic mr, input logic fl, input logic rs);
        logic acc, ret;
        exp_t e;
        ex_valid  = s.v;
        alu_in    = s.alu;
        rs2_in    = s.rs2;
        pc_in     = s.pc;
        imm_in    = s.imm;
        rd_in     = s.rd;
        ctrl_in   = s.c;
        mem_ready = mr;
        flush     = fl;
        reset     = rs;
        acc = s.v && exp_ready && !fl && !rs;
        ret = (cnt > 0) && mr;
        if (acc) begin
            e = '{alu: s.alu, wdata: s.rs2, rd: s.rd, ctrl: s.c, mis: model_mis(s.alu, s.c)};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rs || fl) begin
            cnt = 0;
            exp_q.delete();
            exp_ready = !rs;
            exp_redir = 1'b0;
        end else begin
            cnt = cnt - (ret ? 1 : 0) + (acc ? 1 : 0);
            exp_ready = (cnt < 2);
            exp_redir = acc && s.c.branch && s.alu[0];
            if (exp_redir) exp_rpc = s.pc + s.imm;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mem_valid", mem_valid, cnt > 0);
                check("ex_ready", ex_ready, exp_ready);
                check("redirect_valid", redirect_valid, exp_redir);
                if (exp_redir) check("redirect_pc", redirect_pc, exp_rpc);
                if (mem_valid && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_alu_result", mem_alu_result, e.alu);
                        check("mem_wdata", mem_wdata, e.wdata);
                        check("mem_rd", mem_rd, e.rd);
                        check("mem_ctrl", mem_ctrl, e.ctrl);
                        check("mem_misaligned", mem_misaligned, e.mis);
                    end
                end
            end
        end
    end

    initial begin : driver
        int guard;
        step(idle, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(idle, 1'b0, 1'b0, 1'b1);
        step(idle, 1'b1, 1'b0, 1'b0);

        // Stream of four back-to-back entries with the memory stage always ready
        for (int i = 0; i < 4; i++)
            step(mk(32'h10 + 32'(4 * i), 1'b1, 1'b0, 1'b0, F3_W, 32'h200, 32'h0), 1'b1, 1'b0, 1'b0);
        step(idle, 1'b1, 1'b0, 1'b0);

        // Back-pressure for three cycles, then release
        for (int i = 0; i < 3; i++)
            step(mk(32'h40 + 32'(4 * i), 1'b0, 1'b1, 1'b0, F3_W, 32'h300, 32'h0), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(idle, 1'b1, 1'b0, 1'b0);

        // Taken branch with negative offset, then a not-taken one
        step(mk(32'h1, 1'b0, 1'b0, 1'b1, F3_B, 32'h100, 32'hFFFF_FFF8), 1'b1, 1'b0, 1'b0);
        step(idle, 1'b1, 1'b0, 1'b0);
        step(mk(32'h0, 1'b0, 1'b0, 1'b1, F3_B, 32'h100, 32'hFFFF_FFF8), 1'b1, 1'b0, 1'b0);
        step(idle, 1'b1, 1'b0, 1'b0);

        // Alignment corners: lw/lh at 0x1002, sh/lb at 0x1003
        step(mk(32'h1002, 1'b1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0), 1'b1, 1'b0, 1'b0);
        step(mk(32'h1002, 1'b1, 1'b0, 1'b0, F3_H, 32'h0, 32'h0), 1'b1, 1'b0, 1'b0);
        step(mk(32'h1003, 1'b0, 1'b1, 1'b0, F3_H, 32'h0, 32'h0), 1'b1, 1'b0, 1'b0);
        step(mk(32'h1003, 1'b1, 1'b0, 1'b0, F3_B, 32'h0, 32'h0), 1'b1, 1'b0, 1'b0);
        step(idle, 1'b1, 1'b0, 1'b0);

        // Flush while full, with a taken branch offered in the same cycle
        step(mk(32'h80, 1'b1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0);
        step(mk(32'h84, 1'b1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0);
        step(mk(32'h1, 1'b0, 1'b0, 1'b1, F3_B, 32'h500, 32'h20), 1'b0, 1'b1, 1'b0);
        step(idle, 1'b1, 1'b0, 1'b0);

        // Reset while full
        step(mk(32'h90, 1'b1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0);
        step(mk(32'h1, 1'b0, 1'b0, 1'b1, F3_B, 32'h40, 32'h40), 1'b0, 1'b0, 1'b0);
        step(idle, 1'b0, 1'b0, 1'b1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_ex_ready", ex_ready, 0);
        check("rst_alu_result", mem_alu_result, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_ctrl", mem_ctrl, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        step(idle, 1'b0, 1'b0, 1'b1);
        step(idle, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++)
            step(rand_stim(), $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 99) == 0);

        guard = 0;
        while (cnt > 0 && guard < 10) begin
            step(idle, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage for the RISC-V pipeline. It sits directly downstream of the ALU and captures `ALUResult` together with the execute-stage control and store data. It resolves conditional branches from the ALU compare bit and presents a registered, back-pressurable entry to the memory stage through a 2-entry skid buffer. Memory-stage stalls therefore never create a combinational ready path back into execute.

## Interface
Parameters:
- DATA_WIDTH, 32, width of ALU result, store data, PC and immediate
- REG_ADDR_WIDTH, 5, destination register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill all held entries (hazard unit)
- ex_valid  in  1  execute entry present
- ex_ready  out  1  stage can accept; registered, equals "skid entry empty"
- ALUResult  in  DATA_WIDTH  ALU output; bit 0 is the branch-compare result
- ex_rs2_data  in  DATA_WIDTH  store data
- ex_pc  in  DATA_WIDTH  PC of the entry
- ex_imm  in  DATA_WIDTH  branch offset
- ex_rd  in  REG_ADDR_WIDTH  destination register
- ex_ctrl  in  ex_mem_ctrl_t  reg_write, mem_read, mem_write, mem_to_reg, branch, funct3[2:0]
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory stage accepts head
- mem_alu_result, mem_wdata  out  DATA_WIDTH  head address/result, store data
- mem_rd  out  REG_ADDR_WIDTH; mem_ctrl  out  ex_mem_ctrl_t
- mem_misaligned  out  1  head load/store address misaligned for funct3
- redirect_valid  out  1  one-cycle pulse: taken branch resolved
- redirect_pc  out  DATA_WIDTH  ex_pc + ex_imm of the taken branch

## Operation
- Handshake definitions:
  - Accept = ex_valid & ex_ready.
  - Retire = mem_valid & mem_ready.
- Occupancy FSM. EMPTY, ONE (head only) and TWO (head + skid):
  - EMPTY: accept → ONE (entry loads head).
  - ONE:
    - accept & retire → ONE (new entry loads head).
    - accept & !retire → TWO (new entry loads skid).
    - retire & !accept → EMPTY.
  - TWO:
    - ex_ready = 0, so no accept.
    - retire → ONE (skid moves to head).
- Ordering: strictly FIFO. The head is always the oldest entry.
- ex_ready = (state != TWO), registered, so it is not a function of mem_ready in the same cycle.
- Branch resolution on accept: taken = ex_ctrl.branch & ALUResult[0].
  - If taken, redirect_valid = 1 for exactly one cycle, the cycle after accept.
  - redirect_pc = ex_pc + ex_imm, modulo 2^DATA_WIDTH (wrap-around, no carry out).
  - Branch entries still flow to MEM, with reg_write and mem_write of 0 as decoded upstream.
- Misalignment, computed at capture and stored per entry. It applies only when mem_read | mem_write:
  - funct3 010: addr[1:0] != 0.
  - funct3 001/101: addr[0] != 0.
  - funct3 000/100: never misaligned.
- Flush:
  - Next state is EMPTY and redirect_valid is 0.
  - A simultaneous accept is discarded; flush wins.
  - A simultaneous retire still completes on the MEM side.
- Reset:
  - State EMPTY; mem_valid = 0, redirect_valid = 0.
  - ex_ready = 0 while reset is high, 1 the first cycle after release.
  - Data outputs reset to 0.
  - Reset mid-operation discards all entries with no redirect.

## Timing
- Latency ex → mem_valid: 1 cycle when empty.
- Throughput: 1 entry/cycle while mem_ready = 1.
- Redirect latency: 1 cycle after accept.
- mem_* outputs are stable while mem_valid & !mem_ready.
- All outputs are flop-driven; no combinational in→out path.

## Structure
- Package `pipe_pkg`:
  - `ex_mem_ctrl_t` packed struct.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Occupancy enum (EMPTY, ONE, TWO).
- Sub-module `mem_align_chk`: combinational (addr[1:0], funct3, mem_read, mem_write) → misaligned. Reused later by the load/store unit.

## Test plan
- Stream: 4 back-to-back entries, ALUResult 0x10, 0x14, 0x18, 0x1C, mem_ready = 1 → mem_valid from cycle 1, identical order, ex_ready never drops.
- Back-pressure: mem_ready = 0 for 3 cycles with ex_valid = 1 → two entries held, ex_ready = 0 from the second cycle. Release → FIFO order preserved, no loss or duplication.
- Branch: branch = 1, ALUResult = 1, ex_pc = 0x100, ex_imm = 0xFFFFFFF8 → redirect_valid single pulse next cycle, redirect_pc = 0xF8. ALUResult = 0 → no pulse.
- Misalign:
  - lw at 0x1002 → mem_misaligned = 1.
  - lh at 0x1002 → 0.
  - sh at 0x1003 → 1.
  - lb at 0x1003 → 0.
- Flush in state TWO with a concurrent ex_valid → next cycle mem_valid = 0, ex_ready = 1, no redirect even if the dropped entry was a taken branch.
- Reset asserted in state TWO → outputs zeroed, ex_ready = 0 during reset, 1 after release.
